// File: rtl/ap_arb_pkg.sv
// Shared constants for the two-channel ap_fifo core arbiter.
// States, channel indices and default widths.
package ap_arb_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int LEN_W_DEF  = 16;
    localparam int CNT_W_DEF  = 32;

    typedef logic [0:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 1'b0;
    localparam arb_state_t ST_BUSY = 1'b1;

    localparam logic CH1 = 1'b0;
    localparam logic CH2 = 1'b1;

endpackage

// File: rtl/ap_arb_rr2.sv
// Two-way round-robin picker: the channel that was not served
// last wins a tie.
module ap_arb_rr2
    import ap_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (last == CH2) begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end else begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end
    end

endmodule

// File: rtl/ap_fifo_core_arbiter.sv
// Packet-granular round-robin sharing of one ap_fifo core
// between two host channel FIFO pairs.
module ap_fifo_core_arbiter
    import ap_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              bus_clk,
    input  logic              rst,
    input  logic [1:0]        ch_open,
    input  logic [LEN_W-1:0]  len_in_1,
    input  logic [LEN_W-1:0]  len_in_2,
    input  logic [LEN_W-1:0]  len_out_1,
    input  logic [LEN_W-1:0]  len_out_2,
    input  logic [DATA_W-1:0] ch_dout_1,
    input  logic [DATA_W-1:0] ch_dout_2,
    input  logic              ch_empty_n_1,
    input  logic              ch_empty_n_2,
    output logic              ch_read_1,
    output logic              ch_read_2,
    output logic [DATA_W-1:0] ch_din_1,
    output logic [DATA_W-1:0] ch_din_2,
    input  logic              ch_full_1,
    input  logic              ch_full_2,
    output logic              ch_write_1,
    output logic              ch_write_2,
    output logic [DATA_W-1:0] in_r_dout,
    output logic              in_r_empty_n,
    input  logic              in_r_read,
    input  logic [DATA_W-1:0] out_r_din,
    output logic              out_r_full,
    input  logic              out_r_write,
    output logic              core_rst,
    output logic [1:0]        grant,
    output logic [CNT_W-1:0]  pkt_cnt_1,
    output logic [CNT_W-1:0]  pkt_cnt_2
);

    arb_state_t       state;
    logic             gsel;
    logic             rr_last;
    logic [LEN_W-1:0] l_in;
    logic [LEN_W-1:0] l_out;
    logic [LEN_W-1:0] in_cnt;
    logic [LEN_W-1:0] out_cnt;
    logic [LEN_W-1:0] in_nxt;
    logic [LEN_W-1:0] out_nxt;
    logic [1:0]       elig;
    logic [1:0]       pick;
    logic             busy;
    logic             g_open;
    logic             g_empty_n;
    logic             g_full;
    logic             rd;
    logic             wr;
    logic             done;
    logic             abort;

    assign elig[0] = ch_open[0] & ch_empty_n_1 & (|len_in_1);
    assign elig[1] = ch_open[1] & ch_empty_n_2 & (|len_in_2);

    ap_arb_rr2 u_rr (
        .req  (elig),
        .last (rr_last),
        .gnt  (pick)
    );

    assign busy      = (state == ST_BUSY);
    assign g_open    = gsel ? ch_open[1]   : ch_open[0];
    assign g_empty_n = gsel ? ch_empty_n_2 : ch_empty_n_1;
    assign g_full    = gsel ? ch_full_2    : ch_full_1;

    assign in_r_dout    = busy ? (gsel ? ch_dout_2 : ch_dout_1) : '0;
    assign in_r_empty_n = busy & g_empty_n & (in_cnt < l_in);
    assign rd           = in_r_read & in_r_empty_n;

    // Idle or length reached: the core sees a full FIFO.
    assign out_r_full = ~busy | g_full | (out_cnt >= l_out);
    assign wr         = out_r_write & ~out_r_full;

    assign ch_read_1  = rd & ~gsel;
    assign ch_read_2  = rd & gsel;
    assign ch_write_1 = wr & ~gsel;
    assign ch_write_2 = wr & gsel;
    assign ch_din_1   = (busy & ~gsel) ? out_r_din : '0;
    assign ch_din_2   = (busy & gsel)  ? out_r_din : '0;

    assign in_nxt  = in_cnt + LEN_W'(rd);
    assign out_nxt = out_cnt + LEN_W'(wr);
    assign abort   = busy & ~g_open;
    assign done    = busy & g_open
                   & (in_nxt == l_in) & (out_nxt == l_out);

    always_ff @(posedge bus_clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            grant     <= 2'b00;
            gsel      <= CH1;
            rr_last   <= CH2;
            l_in      <= '0;
            l_out     <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            core_rst  <= 1'b0;
            pkt_cnt_1 <= '0;
            pkt_cnt_2 <= '0;
        end else begin
            core_rst <= 1'b0;
            if (!busy) begin
                if (|pick) begin
                    state   <= ST_BUSY;
                    grant   <= pick;
                    gsel    <= pick[1];
                    l_in    <= pick[1] ? len_in_2  : len_in_1;
                    l_out   <= pick[1] ? len_out_2 : len_out_1;
                    in_cnt  <= '0;
                    out_cnt <= '0;
                end
            end else if (abort) begin
                state    <= ST_IDLE;
                grant    <= 2'b00;
                rr_last  <= gsel;
                core_rst <= 1'b1;
            end else begin
                in_cnt  <= in_nxt;
                out_cnt <= out_nxt;
                if (done) begin
                    state   <= ST_IDLE;
                    grant   <= 2'b00;
                    rr_last <= gsel;
                    if (gsel) pkt_cnt_2 <= pkt_cnt_2 + CNT_W'(1);
                    else      pkt_cnt_1 <= pkt_cnt_1 + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ap_fifo_core_arbiter.sv
// Directed and randomized bench for ap_fifo_core_arbiter with a
// packet-level reference model of ownership and remaining words.
module tb_ap_fifo_core_arbiter;

    localparam int DW = 128;
    localparam int LW = 16;
    localparam int CW = 32;

    logic          bus_clk = 1'b0;
    logic          rst;
    logic [1:0]    ch_open;
    logic [LW-1:0] len_in_1, len_in_2, len_out_1, len_out_2;
    logic [DW-1:0] ch_dout_1, ch_dout_2;
    logic          ch_empty_n_1, ch_empty_n_2;
    logic          ch_read_1, ch_read_2;
    logic [DW-1:0] ch_din_1, ch_din_2;
    logic          ch_full_1, ch_full_2;
    logic          ch_write_1, ch_write_2;
    logic [DW-1:0] in_r_dout;
    logic          in_r_empty_n;
    logic          in_r_read;
    logic [DW-1:0] out_r_din;
    logic          out_r_full;
    logic          out_r_write;
    logic          core_rst;
    logic [1:0]    grant;
    logic [CW-1:0] pkt_cnt_1, pkt_cnt_2;

    ap_fifo_core_arbiter dut (
        .bus_clk      (bus_clk),
        .rst          (rst),
        .ch_open      (ch_open),
        .len_in_1     (len_in_1),
        .len_in_2     (len_in_2),
        .len_out_1    (len_out_1),
        .len_out_2    (len_out_2),
        .ch_dout_1    (ch_dout_1),
        .ch_dout_2    (ch_dout_2),
        .ch_empty_n_1 (ch_empty_n_1),
        .ch_empty_n_2 (ch_empty_n_2),
        .ch_read_1    (ch_read_1),
        .ch_read_2    (ch_read_2),
        .ch_din_1     (ch_din_1),
        .ch_din_2     (ch_din_2),
        .ch_full_1    (ch_full_1),
        .ch_full_2    (ch_full_2),
        .ch_write_1   (ch_write_1),
        .ch_write_2   (ch_write_2),
        .in_r_dout    (in_r_dout),
        .in_r_empty_n (in_r_empty_n),
        .in_r_read    (in_r_read),
        .out_r_din    (out_r_din),
        .out_r_full   (out_r_full),
        .out_r_write  (out_r_write),
        .core_rst     (core_rst),
        .grant        (grant),
        .pkt_cnt_1    (pkt_cnt_1),
        .pkt_cnt_2    (pkt_cnt_2)
    );

    always #5 bus_clk = ~bus_clk;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] q1[$];
    logic [DW-1:0] q2[$];
    int rd_pct = 100;
    int wr_pct = 100;

    // Reference: owner (-1 idle), words still owed each way,
    // preferred channel for the next grant.
    int            m_own, m_inl, m_outl, m_next;
    logic [CW-1:0] m_pk1, m_pk2;
    logic          m_crst;

    int         n_rd1, n_rd2, n_wr1, n_wr2, n_drop, n_x2;
    logic [1:0] gseq[$];
    logic [1:0] prev_grant;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_own = -1; m_inl = 0; m_outl = 0; m_next = 0;
        m_pk1 = '0; m_pk2 = '0; m_crst = 1'b0;
    endtask

    task automatic clr_obs();
        n_rd1 = 0; n_rd2 = 0; n_wr1 = 0; n_wr2 = 0;
        n_drop = 0; n_x2 = 0;
        gseq.delete();
        prev_grant = 2'b00;
    endtask

    function automatic logic [DW-1:0] rword();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic cycle();
        logic [1:0] eg;
        logic ev, ef, erd, ewr, e1, e2;
        int p;
        ch_empty_n_1 = (q1.size() != 0);
        ch_empty_n_2 = (q2.size() != 0);
        ch_dout_1 = ch_empty_n_1 ? q1[0] : '0;
        ch_dout_2 = ch_empty_n_2 ? q2[0] : '0;
        in_r_read   = (int'($urandom_range(99)) < rd_pct);
        out_r_write = (int'($urandom_range(99)) < wr_pct);
        out_r_din   = rword();
        #1;
        if (m_own < 0) begin
            eg = 2'b00; ev = 1'b0; ef = 1'b1;
        end else begin
            eg = (m_own == 0) ? 2'b01 : 2'b10;
            ev = ((m_own == 0) ? ch_empty_n_1 : ch_empty_n_2) && m_inl > 0;
            ef = ((m_own == 0) ? ch_full_1 : ch_full_2) || m_outl == 0;
        end
        erd = in_r_read && ev;
        ewr = out_r_write && !ef;
        chk("grant", DW'(grant), DW'(eg));
        chk("in_r_empty_n", DW'(in_r_empty_n), DW'(ev));
        chk("out_r_full", DW'(out_r_full), DW'(ef));
        chk("ch_read_1", DW'(ch_read_1), DW'(erd && m_own == 0));
        chk("ch_read_2", DW'(ch_read_2), DW'(erd && m_own == 1));
        chk("ch_write_1", DW'(ch_write_1), DW'(ewr && m_own == 0));
        chk("ch_write_2", DW'(ch_write_2), DW'(ewr && m_own == 1));
        chk("core_rst", DW'(core_rst), DW'(m_crst));
        chk("pkt_cnt_1", DW'(pkt_cnt_1), DW'(m_pk1));
        chk("pkt_cnt_2", DW'(pkt_cnt_2), DW'(m_pk2));
        if (ev) chk("in_r_dout", in_r_dout, (m_own == 0) ? q1[0] : q2[0]);
        if (ewr && m_own == 0) chk("ch_din_1", ch_din_1, out_r_din);
        if (ewr && m_own == 1) chk("ch_din_2", ch_din_2, out_r_din);
        n_rd1 += int'(ch_read_1);
        n_rd2 += int'(ch_read_2);
        n_wr1 += int'(ch_write_1);
        n_wr2 += int'(ch_write_2);
        if (out_r_write && out_r_full && grant != 2'b00) n_drop++;
        if (grant == 2'b01 && (ch_read_2 || ch_write_2)) n_x2++;
        if (grant != 2'b00 && prev_grant == 2'b00) gseq.push_back(grant);
        prev_grant = grant;
        e1 = ch_open[0] && ch_empty_n_1 && len_in_1 != 0;
        e2 = ch_open[1] && ch_empty_n_2 && len_in_2 != 0;
        @(posedge bus_clk);
        if (erd && m_own == 0) void'(q1.pop_front());
        if (erd && m_own == 1) void'(q2.pop_front());
        if (rst) begin
            model_reset();
        end else if (m_own < 0) begin
            m_crst = 1'b0;
            if (m_next == 0) p = e1 ? 0 : (e2 ? 1 : -1);
            else             p = e2 ? 1 : (e1 ? 0 : -1);
            if (p >= 0) begin
                m_own  = p;
                m_inl  = int'((p == 0) ? len_in_1 : len_in_2);
                m_outl = int'((p == 0) ? len_out_1 : len_out_2);
            end
        end else begin
            m_crst = 1'b0;
            m_inl  -= int'(erd);
            m_outl -= int'(ewr);
            if (!ch_open[m_own]) begin
                m_crst = 1'b1;
                m_next = 1 - m_own;
                m_own  = -1;
            end else if (m_inl == 0 && m_outl == 0) begin
                if (m_own == 0) m_pk1 = m_pk1 + 1;
                else            m_pk2 = m_pk2 + 1;
                m_next = 1 - m_own;
                m_own  = -1;
            end
        end
        @(negedge bus_clk);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        q1.delete();
        q2.delete();
        ch_open = 2'b00;
        ch_full_1 = 1'b0;
        ch_full_2 = 1'b0;
        rd_pct = 100;
        wr_pct = 100;
        clr_obs();
    endtask

    task automatic push(input int ch, input int n);
        repeat (n) begin
            if (ch == 0) q1.push_back(rword());
            else         q2.push_back(rword());
        end
    endtask

    initial begin
        int k;
        rst = 1'b1;
        ch_open = 2'b00;
        len_in_1 = '0; len_in_2 = '0; len_out_1 = '0; len_out_2 = '0;
        ch_dout_1 = '0; ch_dout_2 = '0;
        ch_empty_n_1 = 1'b0; ch_empty_n_2 = 1'b0;
        ch_full_1 = 1'b0; ch_full_2 = 1'b0;
        in_r_read = 1'b0; out_r_write = 1'b0; out_r_din = '0;
        model_reset();
        clr_obs();
        @(posedge bus_clk);
        @(negedge bus_clk);
        do_reset();

        // single packet
        ch_open = 2'b01; len_in_1 = 4; len_out_1 = 2;
        push(0, 4);
        cycle();
        chk("grant_latency", DW'(grant), DW'(2'b01));
        run(8);
        chk("single_reads", DW'(n_rd1), DW'(4));
        chk("single_writes", DW'(n_wr1), DW'(2));
        chk("single_pkt", DW'(pkt_cnt_1), DW'(1));
        chk("single_idle", DW'(grant), DW'(2'b00));

        // contention
        do_reset();
        ch_open = 2'b11;
        len_in_1 = 2; len_out_1 = 1; len_in_2 = 2; len_out_2 = 1;
        push(0, 4); push(1, 4);
        run(20);
        chk("rr_count", DW'(gseq.size()), DW'(4));
        chk("rr_0", DW'(gseq.size() > 0 ? gseq[0] : 2'b11), DW'(2'b01));
        chk("rr_1", DW'(gseq.size() > 1 ? gseq[1] : 2'b11), DW'(2'b10));
        chk("rr_2", DW'(gseq.size() > 2 ? gseq[2] : 2'b11), DW'(2'b01));
        chk("rr_3", DW'(gseq.size() > 3 ? gseq[3] : 2'b11), DW'(2'b10));
        chk("rr_pkt1", DW'(pkt_cnt_1), DW'(2));
        chk("rr_pkt2", DW'(pkt_cnt_2), DW'(2));
        chk("rr_isolation", DW'(n_x2), DW'(0));

        // back-pressure
        do_reset();
        ch_open = 2'b01; len_in_1 = 4; len_out_1 = 4;
        push(0, 4);
        run(3);
        ch_full_1 = 1'b1;
        n_wr1 = 0;
        run(10);
        chk("bp_no_write", DW'(n_wr1), DW'(0));
        chk("bp_no_done", DW'(pkt_cnt_1), DW'(0));
        ch_full_1 = 1'b0;
        run(4);
        chk("bp_done", DW'(pkt_cnt_1), DW'(1));

        // over-production
        do_reset();
        ch_open = 2'b01; len_in_1 = 4; len_out_1 = 2;
        rd_pct = 25;
        push(0, 4);
        k = 0;
        while (m_pk1 == 0 && k < 200) begin
            cycle();
            k++;
        end
        chk("over_timeout", DW'(k < 200), DW'(1'b1));
        chk("over_writes", DW'(n_wr1), DW'(2));
        chk("over_dropped", DW'(n_drop > 0), DW'(1'b1));
        chk("over_pkt", DW'(pkt_cnt_1), DW'(1));

        // abort
        do_reset();
        ch_open = 2'b11;
        len_in_1 = 4; len_out_1 = 1; len_in_2 = 2; len_out_2 = 1;
        push(0, 4); push(1, 2);
        wr_pct = 0;
        k = 0;
        while (n_rd1 < 2 && k < 10) begin
            cycle();
            k++;
        end
        chk("abort_reads", DW'(n_rd1), DW'(2));
        ch_open = 2'b10;
        rd_pct = 0;
        cycle();
        chk("abort_grant", DW'(grant), DW'(2'b00));
        chk("abort_core_rst", DW'(core_rst), DW'(1'b1));
        rd_pct = 100; wr_pct = 100;
        cycle();
        chk("abort_next", DW'(grant), DW'(2'b10));
        chk("abort_pulse_end", DW'(core_rst), DW'(1'b0));
        run(6);
        chk("abort_pkt1", DW'(pkt_cnt_1), DW'(0));
        chk("abort_pkt2", DW'(pkt_cnt_2), DW'(1));

        // zero lengths
        do_reset();
        ch_open = 2'b11;
        len_in_1 = 3; len_out_1 = 0; len_in_2 = 0; len_out_2 = 1;
        push(0, 3); push(1, 3);
        cycle();
        chk("zero_grant", DW'(grant), DW'(2'b01));
        run(2);
        chk("zero_busy", DW'(grant), DW'(2'b01));
        cycle();
        chk("zero_done", DW'(grant), DW'(2'b00));
        chk("zero_pkt1", DW'(pkt_cnt_1), DW'(1));
        run(8);
        chk("zero_ch2_reads", DW'(n_rd2), DW'(0));
        chk("zero_ch2_pkt", DW'(pkt_cnt_2), DW'(0));

        // randomized traffic
        do_reset();
        ch_open = 2'b11;
        rd_pct = 70; wr_pct = 60;
        for (int i = 0; i < 3000; i++) begin
            if (int'($urandom_range(99)) < 3) ch_open[0] = ~ch_open[0];
            if (int'($urandom_range(99)) < 3) ch_open[1] = ~ch_open[1];
            if (int'($urandom_range(99)) < 20) begin
                len_in_1  = LW'($urandom_range(5));
                len_in_2  = LW'($urandom_range(5));
                len_out_1 = LW'($urandom_range(4));
                len_out_2 = LW'($urandom_range(4));
            end
            ch_full_1 = (int'($urandom_range(99)) < 25);
            ch_full_2 = (int'($urandom_range(99)) < 25);
            if (q1.size() < 6 && int'($urandom_range(99)) < 35) push(0, 1);
            if (q2.size() < 6 && int'($urandom_range(99)) < 35) push(1, 1);
            rst = ($urandom_range(499) == 0);
            cycle();
        end
        rst = 1'b0;

        // reset while busy
        do_reset();
        ch_open = 2'b01; len_in_1 = 4; len_out_1 = 4;
        rd_pct = 0; wr_pct = 0;
        push(0, 4);
        run(3);
        chk("rstbusy_grant", DW'(grant), DW'(2'b01));
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_grant", DW'(grant), DW'(2'b00));
        chk("rst_core_rst", DW'(core_rst), DW'(1'b0));
        chk("rst_out_full", DW'(out_r_full), DW'(1'b1));
        chk("rst_in_valid", DW'(in_r_empty_n), DW'(1'b0));
        chk("rst_pkt1", DW'(pkt_cnt_1), DW'(0));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ap_fifo_core_arbiter.md
Name: ap_fifo_core_arbiter

Overview:
- Shares one HLS ap_fifo core (128-bit in/out streams) between two host channel pairs.
- Each channel pair is a to-function FIFO read side and a from-function FIFO write side.
- Arbitration is packet-granular and round-robin. While a channel holds the grant, exactly LEN_IN words flow channel→core and exactly LEN_OUT words flow core→channel.
- Sits between the channel FIFOs and the core, in the bus_clk domain. Per-channel packet lengths come from the mem_8 register array.

Parameters:
- DATA_W, 128, stream word width.
- LEN_W, 16, width of packet-length registers and word counters.
- CNT_W, 32, width of per-channel completed-packet counters.

Ports:
- bus_clk  in  1  sole clock.
- rst  in  1  synchronous active-high reset.
- ch_open  in  2  per-channel open flag (write OR read device open); bit0=ch1, bit1=ch2.
- len_in_1, len_in_2  in  LEN_W  words fed to core per packet; 0 means never grant.
- len_out_1, len_out_2  in  LEN_W  words returned by core per packet; 0 allowed.
- ch_dout_1, ch_dout_2  in  DATA_W  to-function FIFO head word.
- ch_empty_n_1, ch_empty_n_2  in  1  to-function FIFO has data.
- ch_read_1, ch_read_2  out  1  pop to-function FIFO.
- ch_din_1, ch_din_2  out  DATA_W  word to from-function FIFO.
- ch_full_1, ch_full_2  in  1  from-function FIFO full.
- ch_write_1, ch_write_2  out  1  push from-function FIFO.
- in_r_dout  out  DATA_W  core input data.
- in_r_empty_n  out  1  core input valid.
- in_r_read  in  1  core pops input.
- out_r_din  in  DATA_W  core output data.
- out_r_full  out  1  core output back-pressure.
- out_r_write  in  1  core pushes output.
- core_rst  out  1  one-cycle active-high core reset pulse on abort.
- grant  out  2  one-hot current owner; 0 when idle.
- pkt_cnt_1, pkt_cnt_2  out  CNT_W  completed packets per channel.

Behaviour:
- Reset values: grant=0, state IDLE, counters 0, pkt_cnt 0, core_rst=0, rr_last=ch2 (so ch1 wins first). All handshake outputs are 0, except out_r_full=1.
- Eligibility: channel k is eligible iff ch_open[k], empty_n_k, and len_in_k!=0.
- IDLE: if any channel is eligible, grant the one after rr_last. Latch its len_in/len_out into L_IN/L_OUT, clear in_cnt/out_cnt, go to BUSY next cycle.
- Grant latency is 1 cycle from eligibility.
- If both channels are eligible, the non-rr_last channel wins.
- BUSY, input path (combinational from registered state), g = granted channel:
  - in_r_dout = ch_dout_g.
  - in_r_empty_n = ch_empty_n_g & (in_cnt < L_IN).
  - ch_read_g = in_r_read & in_r_empty_n.
  - in_cnt increments on ch_read_g.
- BUSY, output path:
  - out_r_full = ch_full_g | (out_cnt >= L_OUT).
  - ch_din_g = out_r_din.
  - ch_write_g = out_r_write & !out_r_full.
  - out_cnt increments on ch_write_g.
  - A core write while out_r_full=1 is dropped.
- Non-granted channels: read=0, write=0.
- Input and output transfers may occur in the same cycle.
- Completion: when in_cnt==L_IN and out_cnt==L_OUT (counting the current cycle's transfers), the block:
  - goes to IDLE next cycle;
  - increments pkt_cnt_g, wrapping at 2^CNT_W;
  - sets rr_last=g;
  - clears grant.
- Back-to-back packets therefore have a 1-cycle IDLE bubble.
- Length inputs changing mid-packet have no effect; the lengths latched at grant are used.
- Abort: if ch_open[g] drops during BUSY:
  - next cycle → IDLE, grant=0, core_rst=1 for exactly one cycle;
  - pkt_cnt is not incremented; rr_last=g.
- rst during BUSY: everything returns to reset values next cycle; core_rst is not pulsed.

Decomposition:
- Shared package ap_arb_pkg holds: state enum (IDLE, BUSY), channel index constants CH1=0/CH2=1, and DATA_W/LEN_W defaults.
- One natural sub-module, ap_arb_rr2: 2-way round-robin picker (req[1:0], last → one-hot gnt).
- Muxing and counters stay in the top level.

Test Plan:
- Single packet: ch1 open, len_in_1=4, len_out_1=2, 4 words queued; core reads every cycle, writes 2 words.
  - Required: grant=01 one cycle after empty_n.
  - Required: exactly 4 ch_read_1 and 2 ch_write_1.
  - Required: pkt_cnt_1=1, grant→00.
- Contention: both channels eligible at once with len_in=2, len_out=1.
  - Required: grant order ch1, ch2, ch1, ch2 over 4 packets.
  - Required: pkt_cnt_1=2, pkt_cnt_2=2.
  - Required: no ch2 handshake while grant=01.
- Back-pressure: hold ch_full_1=1 for 10 cycles mid-output.
  - Required: out_r_full=1 for those cycles; no ch_write_1.
  - Required: completion occurs only after ch_full_1 deasserts.
- Over-production: core attempts a 3rd write when len_out=2.
  - Required: out_r_full=1; the write is dropped; ch_write stays 0.
- Abort: drop ch_open[0] after 2 of 4 input words.
  - Required: next cycle grant=00 and core_rst pulses 1 cycle.
  - Required: pkt_cnt_1 unchanged; ch2 is granted next if eligible.
- Zero lengths: len_in_2=0 with data present → ch2 never granted. len_out_1=0 → packet completes on the last input read.
